buckeye_shift_ctrl: RTL and testbench

- Parametrised controller that loads configuration words serially into a bank of Buckeye amplifier shift registers and reads back their previous contents.
- Drives the AMPIN, AMPCLK and AMPOUT lines.
- Successor to the fixed 6-chip, 48-bit Buckeye path. Generalised in chip count, chip length and shift-clock rate.
- Adds per-chip masking, readback capture and a write/verify match flag. Sits between the JTAG user-register decode (function 10 mask, function 11 shift) and the front-end pins.

---
 rtl/buckeye_pkg.sv | 25 ++
 rtl/bky_chain_shifter.sv | 58 +++++
 rtl/buckeye_shift_ctrl.sv | 169 ++++++++++++++++
 tb/tb_buckeye_shift_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buckeye_pkg.sv
// Shared types and helpers for the Buckeye amplifier shift controller.
// No logic of its own; imported by the controller and its per-chain shifter.
package buckeye_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int N_CHIP_DEF    = 6;
    localparam int CHIP_BITS_DEF = 48;

    // Ceiling log2, never below 1 so single-entry ranges still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bky_chain_shifter.sv
// One Buckeye chain: working shift register, readback capture and verify compare.
// Acts on single-cycle strobes from the shared sequencer; no backpressure of its own.
module bky_chain_shifter
    import buckeye_pkg::*;
#(
    parameter int CHIP_BITS = CHIP_BITS_DEF
) (
    input  logic                 core_clk,
    input  logic                 rst,
    input  logic                 active,
    input  logic                 load,
    input  logic                 load_en,
    input  logic                 en,
    input  logic                 sample,
    input  logic                 step,
    input  logic                 last,
    input  logic [CHIP_BITS-1:0] load_word,
    input  logic [CHIP_BITS-1:0] ref_word,
    input  logic                 amp_out,
    output logic                 amp_in,
    output logic                 amp_clk,
    output logic                 match,
    output logic [CHIP_BITS-1:0] readback
);

    logic [CHIP_BITS-1:0] work;

    always_ff @(posedge core_clk) begin
        if (rst) begin
            work    <= '0;
            amp_in  <= 1'b0;
            amp_clk <= 1'b0;
            match   <= 1'b0;
            // An aborted shift leaves the partially captured readback visible.
            if (!active) begin
                readback <= '0;
            end
        end else begin
            if (load) begin
                work   <= load_en ? load_word : '0;
                amp_in <= load_en & load_word[0];
            end
            if (sample && en) begin
                readback <= {amp_out, readback[CHIP_BITS-1:1]};
                amp_clk  <= 1'b1;
            end
            if (step) begin
                work    <= {1'b0, work[CHIP_BITS-1:1]};
                amp_clk <= 1'b0;
                amp_in  <= en & ~last & work[1];
                if (last) begin
                    match <= en & (readback == ref_word);
                end
            end
        end
    end

endmodule

// File: rtl/buckeye_shift_ctrl.sv
// Serially loads shadow words into N_CHIP Buckeye chains while capturing their old contents.
// A shift takes CHIP_BITS*2*CLK_DIV+1 cycles; requests arriving while BUSY are dropped and flagged on REJ.
module buckeye_shift_ctrl
    import buckeye_pkg::*;
#(
    parameter int                N_CHIP       = N_CHIP_DEF,
    parameter int                CHIP_BITS    = CHIP_BITS_DEF,
    parameter int                CLK_DIV      = 4,
    parameter logic [N_CHIP-1:0] MASK_DEFAULT = {N_CHIP{1'b1}}
) (
    input  logic                     CMSCLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic                     MASK_LD,
    input  logic [N_CHIP-1:0]        MASK_IN,
    input  logic                     WR_EN,
    input  logic [clog2(N_CHIP)-1:0] WR_CHIP,
    input  logic [CHIP_BITS-1:0]     WR_DATA,
    input  logic [clog2(N_CHIP)-1:0] RD_CHIP,
    output logic [CHIP_BITS-1:0]     RD_DATA,
    output logic [N_CHIP-1:0]        MASK,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [N_CHIP-1:0]        MATCH,
    output logic                     REJ,
    output logic [N_CHIP-1:0]        AMPIN,
    output logic [N_CHIP-1:0]        AMPCLK,
    input  logic [N_CHIP-1:0]        AMPOUT
);

    localparam int PH_W  = clog2(CLK_DIV);
    localparam int BIT_W = clog2(CHIP_BITS);

    state_t               state;
    logic [PH_W-1:0]      phase;
    logic [BIT_W-1:0]     bit_idx;
    logic                 busy;
    logic                 done;
    logic                 rej;
    logic [N_CHIP-1:0]    mask;
    logic [N_CHIP-1:0]    mask_nxt;
    logic [CHIP_BITS-1:0] shadow    [N_CHIP];
    logic [CHIP_BITS-1:0] load_word [N_CHIP];
    logic [CHIP_BITS-1:0] rb        [N_CHIP];

    logic idle, phase_end, bit_last, load, sample, step, wr_ok;

    assign idle      = (state == ST_IDLE);
    assign phase_end = (phase == PH_W'(CLK_DIV - 1));
    assign bit_last  = (bit_idx == BIT_W'(CHIP_BITS - 1));
    assign load      = idle & START;
    assign sample    = (state == ST_LO) & phase_end;
    assign step      = (state == ST_HI) & phase_end;
    assign wr_ok     = (int'(WR_CHIP) < N_CHIP);
    assign mask_nxt  = (idle && MASK_LD) ? MASK_IN : mask;

    assign MASK = mask;
    assign BUSY = busy;
    assign DONE = done;
    assign REJ  = rej;

    always_ff @(posedge CMSCLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rej     <= 1'b0;
        end else begin
            done <= 1'b0;
            rej  <= busy & (START | WR_EN | MASK_LD);
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state   <= ST_LO;
                        busy    <= 1'b1;
                        phase   <= '0;
                        bit_idx <= '0;
                    end
                end
                ST_LO: begin
                    if (phase_end) begin
                        phase <= '0;
                        state <= ST_HI;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_HI: begin
                    if (phase_end) begin
                        phase <= '0;
                        if (bit_last) begin
                            bit_idx <= '0;
                            state   <= ST_FIN;
                            done    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            state   <= ST_LO;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shadow and mask only move while idle, so they equal their START-time values throughout a shift.
    always_ff @(posedge CMSCLK) begin
        if (RST) begin
            for (int c = 0; c < N_CHIP; c++) begin
                shadow[c] <= '0;
            end
            mask <= MASK_DEFAULT;
        end else if (idle) begin
            if (WR_EN && wr_ok) begin
                shadow[WR_CHIP] <= WR_DATA;
            end
            if (MASK_LD) begin
                mask <= MASK_IN;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_CHIP; c++) begin
            load_word[c] = (WR_EN && (int'(WR_CHIP) == c)) ? WR_DATA : shadow[c];
        end
    end

    always_comb begin
        RD_DATA = '0;
        for (int c = 0; c < N_CHIP; c++) begin
            if (int'(RD_CHIP) == c) begin
                RD_DATA = rb[c];
            end
        end
    end

    for (genvar c = 0; c < N_CHIP; c++) begin : g_chain
        bky_chain_shifter #(
            .CHIP_BITS (CHIP_BITS)
        ) u_chain (
            .core_clk  (CMSCLK),
            .rst       (RST),
            .active    (busy),
            .load      (load),
            .load_en   (mask_nxt[c]),
            .en        (mask[c]),
            .sample    (sample),
            .step      (step),
            .last      (bit_last),
            .load_word (load_word[c]),
            .ref_word  (shadow[c]),
            .amp_out   (AMPOUT[c]),
            .amp_in    (AMPIN[c]),
            .amp_clk   (AMPCLK[c]),
            .match     (MATCH[c]),
            .readback  (rb[c])
        );
    end

endmodule

// File: tb/tb_buckeye_shift_ctrl.sv
// Bench for buckeye_shift_ctrl: chip shift-register models, table vectors, random shifts vs an abstract model.
// A second small instance covers the fast-clock abort-and-restart case.
module tb_buckeye_shift_ctrl;
    import buckeye_pkg::*;

    localparam int NC        = 6;
    localparam int CB        = 48;
    localparam int CD        = 4;
    localparam int SHIFT_CYC = CB * 2 * CD + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, mask_ld, wr_en;
    logic [NC-1:0] mask_in;
    logic [2:0]    wr_chip, rd_chip;
    logic [CB-1:0] wr_data, rd_data;
    logic [NC-1:0] mask, match, ampin, ampclk, ampout;
    logic          busy, done, rej;

    buckeye_shift_ctrl #(
        .N_CHIP(NC), .CHIP_BITS(CB), .CLK_DIV(CD), .MASK_DEFAULT(6'h3F)
    ) dut (
        .CMSCLK(clk), .RST(rst), .START(start), .MASK_LD(mask_ld), .MASK_IN(mask_in),
        .WR_EN(wr_en), .WR_CHIP(wr_chip), .WR_DATA(wr_data), .RD_CHIP(rd_chip),
        .RD_DATA(rd_data), .MASK(mask), .BUSY(busy), .DONE(done), .MATCH(match),
        .REJ(rej), .AMPIN(ampin), .AMPCLK(ampclk), .AMPOUT(ampout)
    );

    logic       s_rst, s_start, s_busy, s_done, s_rej;
    logic [1:0] s_mask, s_match, s_ampin, s_ampclk;
    logic [7:0] s_rd_data;

    buckeye_shift_ctrl #(
        .N_CHIP(2), .CHIP_BITS(8), .CLK_DIV(1), .MASK_DEFAULT(2'b11)
    ) dut_small (
        .CMSCLK(clk), .RST(s_rst), .START(s_start), .MASK_LD(1'b0), .MASK_IN(2'b00),
        .WR_EN(1'b0), .WR_CHIP(1'b0), .WR_DATA(8'h00), .RD_CHIP(1'b0),
        .RD_DATA(s_rd_data), .MASK(s_mask), .BUSY(s_busy), .DONE(s_done), .MATCH(s_match),
        .REJ(s_rej), .AMPIN(s_ampin), .AMPCLK(s_ampclk), .AMPOUT(2'b00)
    );

    // Physical chip models: shift on each rising AMPCLK, AMPOUT is bit 0.
    logic [CB-1:0] chip     [NC];
    int            edge_cnt [NC];
    logic [NC-1:0] clk_prev;

    initial begin
        for (int c = 0; c < NC; c++) begin
            chip[c]     = '0;
            edge_cnt[c] = 0;
        end
        clk_prev = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (ampclk[c] && !clk_prev[c]) begin
                    chip[c]     = {ampin[c], chip[c][CB-1:1]};
                    edge_cnt[c] = edge_cnt[c] + 1;
                end
            end
            clk_prev = ampclk;
        end
    end

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            ampout[c] = chip[c][0];
        end
    end

    // Abstract reference: what each chip, readback and match flag should hold after a shift.
    logic [CB-1:0] m_shadow [NC];
    logic [CB-1:0] exp_chip [NC];
    logic [CB-1:0] exp_rb   [NC];
    logic [NC-1:0] m_mask, exp_match;
    int            edge_pre [NC];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [CB-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[CB-1:0];
    endfunction

    function automatic void model_shift();
        for (int c = 0; c < NC; c++) begin
            if (m_mask[c]) begin
                exp_rb[c]   = exp_chip[c];
                exp_chip[c] = m_shadow[c];
            end
            exp_match[c] = m_mask[c] && (exp_rb[c] == m_shadow[c]);
        end
    endfunction

    task automatic do_write(input int c, input logic [CB-1:0] d);
        wr_en = 1'b1; wr_chip = 3'(c); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        m_shadow[c] = d;
    endtask

    task automatic do_mask(input logic [NC-1:0] m);
        mask_ld = 1'b1; mask_in = m;
        @(negedge clk);
        mask_ld = 1'b0;
        m_mask = m;
    endtask

    task automatic run_shift(input bit wr, input int c, input logic [CB-1:0] d,
                             output int cyc, output int dones);
        for (int i = 0; i < NC; i++) edge_pre[i] = edge_cnt[i];
        start = 1'b1;
        if (wr) begin
            wr_en = 1'b1; wr_chip = 3'(c); wr_data = d;
            m_shadow[c] = d;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        cyc = 0; dones = 0;
        while (busy === 1'b1 && cyc < 4000) begin
            cyc++;
            if (done) dones++;
            @(negedge clk);
        end
        model_shift();
    endtask

    task automatic check_all(input string tag);
        chk({tag, " mask"}, 64'(mask), 64'(m_mask));
        chk({tag, " match"}, 64'(match), 64'(exp_match));
        for (int c = 0; c < NC; c++) begin
            rd_chip = 3'(c);
            #1;
            chk($sformatf("%s rd_data[%0d]", tag, c), 64'(rd_data), 64'(exp_rb[c]));
            chk($sformatf("%s chip[%0d]", tag, c), 64'(chip[c]), 64'(exp_chip[c]));
            chk($sformatf("%s edges[%0d]", tag, c), 64'(edge_cnt[c] - edge_pre[c]),
                64'(m_mask[c] ? CB : 0));
        end
        @(negedge clk);
    endtask

    task automatic shift_check(input string tag, input bit wr, input int c, input logic [CB-1:0] d);
        int cyc, dn;
        run_shift(wr, c, d, cyc, dn);
        chk({tag, " busy_cycles"}, 64'(cyc), 64'(SHIFT_CYC));
        chk({tag, " done_pulses"}, 64'(dn), 64'd1);
        check_all(tag);
    endtask

    typedef struct {
        logic [NC-1:0] mask;
        bit            wr_seq;
        bit            wr0;
        logic [CB-1:0] d0;
        int            chk_chip;
        logic [CB-1:0] exp_rd;
        logic [NC-1:0] exp_match;
        logic [NC-1:0] exp_toggle;
    } vec_t;

    vec_t          vt [4];
    logic [NC-1:0] tog;
    int            cyc, dn, rj, hi;
    logic [CB-1:0] d;
    bit            sw;
    int            nw;

    initial begin
        vt[0] = '{6'h3F, 1'b0, 1'b1, 48'hA5A5_0F0F_1234, 0, 48'h0, 6'b111110, 6'h3F};
        vt[1] = '{6'h3F, 1'b0, 1'b0, 48'h0, 0, 48'hA5A5_0F0F_1234, 6'h3F, 6'h3F};
        vt[2] = '{6'h05, 1'b1, 1'b0, 48'h0, 1, 48'h0, 6'h00, 6'h05};
        vt[3] = '{6'h05, 1'b0, 1'b0, 48'h0, 0, 48'h1, 6'h05, 6'h05};

        for (int c = 0; c < NC; c++) begin
            m_shadow[c] = '0; exp_chip[c] = '0; exp_rb[c] = '0; edge_pre[c] = 0;
        end
        m_mask = 6'h3F; exp_match = '0;

        rst = 1'b1; s_rst = 1'b1; start = 1'b0; s_start = 1'b0;
        mask_ld = 1'b0; mask_in = '0; wr_en = 1'b0; wr_chip = '0; wr_data = '0; rd_chip = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; s_rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst mask", 64'(mask), 64'h3F);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst rej", 64'(rej), 64'd0);
        chk("rst match", 64'(match), 64'd0);
        chk("rst ampclk", 64'(ampclk), 64'd0);
        chk("rst ampin", 64'(ampin), 64'd0);
        chk("rst small mask", 64'(s_mask), 64'h3);
        for (int c = 0; c < NC; c++) begin
            rd_chip = 3'(c);
            #1;
            chk($sformatf("rst rd_data[%0d]", c), 64'(rd_data), 64'd0);
        end
        @(negedge clk);

        // Table vectors: single shift, verify pass, masking
        for (int i = 0; i < 4; i++) begin
            if (m_mask != vt[i].mask) do_mask(vt[i].mask);
            if (vt[i].wr_seq) begin
                for (int c = 0; c < NC; c++) do_write(c, CB'(c + 1));
            end
            if (vt[i].wr0) do_write(0, vt[i].d0);
            shift_check($sformatf("vec%0d", i), 1'b0, 0, '0);
            for (int c = 0; c < NC; c++) tog[c] = (edge_cnt[c] != edge_pre[c]);
            rd_chip = 3'(vt[i].chk_chip);
            #1;
            chk($sformatf("vec%0d rd_data", i), 64'(rd_data), 64'(vt[i].exp_rd));
            chk($sformatf("vec%0d match", i), 64'(match), 64'(vt[i].exp_match));
            chk($sformatf("vec%0d toggled", i), 64'(tog), 64'(vt[i].exp_toggle));
            @(negedge clk);
        end

        // Requests during a shift are rejected and leave shadow and mask alone
        do_mask(6'h3F);
        for (int i = 0; i < NC; i++) edge_pre[i] = edge_cnt[i];
        wr_chip = 3'd3; wr_data = ~m_shadow[3]; mask_in = ~m_mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; dn = 0; rj = 0;
        while (busy === 1'b1 && cyc < 4000) begin
            cyc++;
            if (done) dn++;
            if (rej) rj++;
            start = (cyc == 10); wr_en = (cyc == 10); mask_ld = (cyc == 10);
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0; mask_ld = 1'b0;
        model_shift();
        chk("busyrej rej_pulses", 64'(rj), 64'd1);
        chk("busyrej done_pulses", 64'(dn), 64'd1);
        chk("busyrej busy_cycles", 64'(cyc), 64'(SHIFT_CYC));
        check_all("busyrej");
        chk("busyrej idle_after", 64'(busy), 64'd0);

        // Random masks, writes and START-coincident writes against the reference
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 2) == 0) do_mask(NC'($urandom_range(0, 63)));
            nw = int'($urandom_range(0, 3));
            for (int k = 0; k < nw; k++) do_write(int'($urandom_range(0, NC - 1)), rnd48());
            sw = ($urandom_range(0, 3) == 0);
            d  = rnd48();
            shift_check($sformatf("rnd%0d", it), sw, int'($urandom_range(0, NC - 1)), d);
        end

        // Fast instance: reset at busy cycle 7 aborts, then a clean shift
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        dn = 0;
        for (int k = 1; k < 7; k++) begin
            if (s_done) dn++;
            @(negedge clk);
        end
        s_rst = 1'b1;
        @(negedge clk);
        chk("abort ampclk", 64'(s_ampclk), 64'd0);
        chk("abort busy", 64'(s_busy), 64'd0);
        chk("abort ampin", 64'(s_ampin), 64'd0);
        s_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (s_done || s_busy) dn++;
            @(negedge clk);
        end
        chk("abort no_done", 64'(dn), 64'd0);
        chk("abort readback", 64'(s_rd_data), 64'd0);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cyc = 0; dn = 0; hi = 0;
        while (s_busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (s_done) dn++;
            if (s_ampclk[0]) hi++;
            @(negedge clk);
        end
        chk("small busy_cycles", 64'(cyc), 64'd17);
        chk("small done_pulses", 64'(dn), 64'd1);
        chk("small ampclk_pulses", 64'(hi), 64'd8);
        chk("small match", 64'(s_match), 64'h3);
        chk("small rej", 64'(s_rej), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
